// File: rtl/mac_package.sv
// Shared definitions for the MAC tile sequencer: control-slave register map,
// sequencer state encoding and the acquire-failure marker.
package mac_package;

    // Register offsets of the accelerator peripheral control slave
    localparam logic [31:0] MAC_SEQ_OFFS_TRIGGER    = 32'h0000_0000;
    localparam logic [31:0] MAC_SEQ_OFFS_ACQUIRE    = 32'h0000_0004;
    localparam logic [31:0] MAC_SEQ_OFFS_IO_BASE    = 32'h0000_0040;
    localparam logic [31:0] MAC_SEQ_OFFS_PARAM_BASE = 32'h0000_0050;

    // Acquire read returns this value when no context is free
    localparam logic [31:0] MAC_SEQ_ACQUIRE_FAIL = 32'hFFFF_FFFF;

    // Four address streams (A, B, C, D) and four job parameters
    localparam int MAC_SEQ_NB_STREAMS = 4;
    localparam int MAC_SEQ_NB_PARAMS  = 4;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_ACQ,
        SEQ_ACQ_WAIT,
        SEQ_RETRY,
        SEQ_PROG,
        SEQ_TRIG,
        SEQ_WAIT_EVT,
        SEQ_NEXT,
        SEQ_DONE
    } mac_seq_state_t;

endpackage

// File: rtl/mac_tile_addr_gen.sv
// Per-stream address accumulators: loaded with the tile-0 base and stride,
// advanced by one stride (mod 2^32) per completed tile.
module mac_tile_addr_gen
    import mac_package::*;
(
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                load_i,
    input  logic                                step_i,
    input  logic [MAC_SEQ_NB_STREAMS-1:0][31:0] base_i,
    input  logic [MAC_SEQ_NB_STREAMS-1:0][31:0] stride_i,
    output logic [MAC_SEQ_NB_STREAMS-1:0][31:0] addr_o
);

    generate
        for (genvar gi = 0; gi < MAC_SEQ_NB_STREAMS; gi++) begin : g_stream
            logic [31:0] acc_reg;
            logic [31:0] stride_reg;

            // Load base/stride at sequence start, accumulate once per tile
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    acc_reg    <= '0;
                    stride_reg <= '0;
                end else if (clear_i) begin
                    acc_reg    <= '0;
                    stride_reg <= '0;
                end else if (load_i) begin
                    acc_reg    <= base_i[gi];
                    stride_reg <= stride_i[gi];
                end else if (step_i) begin
                    acc_reg    <= acc_reg + stride_reg;
                end
            end

            assign addr_o[gi] = acc_reg;
        end
    endgenerate

endmodule

// File: rtl/mac_tile_seq.sv
// Tile job sequencer: for each tile acquires an accelerator context, programs
// the stream addresses and job parameters, triggers the job and waits for the
// completion event. Single-outstanding master on the periph control bus.
module mac_tile_seq
    import mac_package::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ID           = 10,
    parameter int          RETRY_CYCLES = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [15:0]   n_tiles_i,
    input  logic [31:0]   a_base_i,
    input  logic [31:0]   b_base_i,
    input  logic [31:0]   c_base_i,
    input  logic [31:0]   d_base_i,
    input  logic [31:0]   a_stride_i,
    input  logic [31:0]   b_stride_i,
    input  logic [31:0]   c_stride_i,
    input  logic [31:0]   d_stride_i,
    input  logic [31:0]   nb_iter_i,
    input  logic [31:0]   len_iter_i,
    input  logic [31:0]   shift_simplemul_i,
    input  logic [31:0]   vectstride_i,
    output logic          req_o,
    output logic [31:0]   add_o,
    output logic          wen_o,
    output logic [3:0]    be_o,
    output logic [31:0]   data_o,
    output logic [ID-1:0] id_o,
    input  logic          gnt_i,
    input  logic          r_valid_i,
    input  logic [31:0]   r_data_i,
    input  logic          evt_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   tile_idx_o
);

    localparam int               CNT_W    = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYCLES - 1);

    mac_seq_state_t state_reg, state_next;
    logic [2:0]       k_reg, k_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      tile_idx_reg, tile_idx_next, tile_inc;
    logic             evt_seen_reg, evt_seen_next;
    logic [15:0]      n_tiles_reg;
    logic [MAC_SEQ_NB_PARAMS-1:0][31:0]  param_reg, param_in;
    logic [MAC_SEQ_NB_STREAMS-1:0][31:0] base_in, stride_in, addr_cur;
    logic             addr_load, addr_step;
    logic             req_reg, req_next, wen_reg, wen_next, busy_reg, done_reg;
    logic [31:0]      add_reg, add_next, data_reg, data_next;

    assign base_in   = {d_base_i, c_base_i, b_base_i, a_base_i};
    assign stride_in = {d_stride_i, c_stride_i, b_stride_i, a_stride_i};
    assign param_in  = {vectstride_i, shift_simplemul_i, len_iter_i, nb_iter_i};
    assign tile_inc  = tile_idx_reg + 16'd1;

    mac_tile_addr_gen u_addr_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (base_in),
        .stride_i (stride_in),
        .addr_o   (addr_cur)
    );

    // Next-state and counter logic; clear overrides every transition
    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        cnt_next      = cnt_reg;
        tile_idx_next = tile_idx_reg;
        evt_seen_next = evt_seen_reg | evt_i;
        addr_load     = 1'b0;
        addr_step     = 1'b0;
        case (state_reg)
            SEQ_IDLE: if (start_i) begin
                addr_load     = 1'b1;
                tile_idx_next = '0;
                state_next    = (n_tiles_i == 16'd0) ? SEQ_DONE : SEQ_ACQ;
            end
            SEQ_ACQ: if (gnt_i) state_next = SEQ_ACQ_WAIT;
            SEQ_ACQ_WAIT: if (r_valid_i) begin
                if (r_data_i == MAC_SEQ_ACQUIRE_FAIL) begin
                    state_next = SEQ_RETRY;
                    cnt_next   = '0;
                end else begin
                    state_next = SEQ_PROG;
                    k_next     = '0;
                end
            end
            SEQ_RETRY: begin
                if (cnt_reg == CNT_LAST) state_next = SEQ_ACQ;
                else                     cnt_next   = cnt_reg + 1'b1;
            end
            SEQ_PROG: if (gnt_i) begin
                k_next = k_reg + 3'd1;
                if (k_reg == 3'd7) state_next = SEQ_TRIG;
            end
            // An event arriving with the trigger grant belongs to the previous job
            SEQ_TRIG: if (gnt_i) begin
                evt_seen_next = 1'b0;
                state_next    = SEQ_WAIT_EVT;
            end
            SEQ_WAIT_EVT: if (evt_seen_reg) state_next = SEQ_NEXT;
            SEQ_NEXT: begin
                addr_step     = 1'b1;
                tile_idx_next = tile_inc;
                state_next    = (tile_inc == n_tiles_reg) ? SEQ_DONE : SEQ_ACQ;
            end
            SEQ_DONE: state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
        if (clear_i) begin
            state_next    = SEQ_IDLE;
            k_next        = '0;
            cnt_next      = '0;
            tile_idx_next = '0;
            evt_seen_next = 1'b0;
            addr_load     = 1'b0;
            addr_step     = 1'b0;
        end
    end

    // Bus request contents derived from the upcoming state so they are registered
    // and stay unchanged while a request waits for its grant
    always_comb begin
        req_next  = 1'b0;
        add_next  = add_reg;
        wen_next  = wen_reg;
        data_next = data_reg;
        case (state_next)
            SEQ_ACQ: begin
                req_next  = 1'b1;
                add_next  = BASE_ADDR + MAC_SEQ_OFFS_ACQUIRE;
                wen_next  = 1'b1;
                data_next = '0;
            end
            SEQ_PROG: begin
                req_next = 1'b1;
                wen_next = 1'b0;
                if (!k_next[2]) begin
                    add_next  = BASE_ADDR + MAC_SEQ_OFFS_IO_BASE + {28'd0, k_next[1:0], 2'b00};
                    data_next = addr_cur[k_next[1:0]];
                end else begin
                    add_next  = BASE_ADDR + MAC_SEQ_OFFS_PARAM_BASE + {28'd0, k_next[1:0], 2'b00};
                    data_next = param_reg[k_next[1:0]];
                end
            end
            SEQ_TRIG: begin
                req_next  = 1'b1;
                add_next  = BASE_ADDR + MAC_SEQ_OFFS_TRIGGER;
                wen_next  = 1'b0;
                data_next = '0;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= SEQ_IDLE;
            k_reg        <= '0;
            cnt_reg      <= '0;
            tile_idx_reg <= '0;
            evt_seen_reg <= 1'b0;
            req_reg      <= 1'b0;
            add_reg      <= '0;
            wen_reg      <= 1'b1;
            data_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            cnt_reg      <= cnt_next;
            tile_idx_reg <= tile_idx_next;
            evt_seen_reg <= evt_seen_next;
            req_reg      <= req_next;
            add_reg      <= add_next;
            wen_reg      <= wen_next;
            data_reg     <= data_next;
            busy_reg     <= (state_next != SEQ_IDLE);
            done_reg     <= (state_next == SEQ_DONE);
        end
    end

    // Snapshot of the job configuration taken when a sequence starts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_tiles_reg <= '0;
            param_reg   <= '0;
        end else if (addr_load) begin
            n_tiles_reg <= n_tiles_i;
            param_reg   <= param_in;
        end
    end

    assign req_o      = req_reg;
    assign add_o      = add_reg;
    assign wen_o      = wen_reg;
    assign be_o       = 4'hF;
    assign data_o     = data_reg;
    assign id_o       = '0;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;
    assign tile_idx_o = tile_idx_reg;

endmodule
